// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Byte FIFO with launch controller feeding uart_tx one frame at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              ovf_clr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_data_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              busy
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        mem_q [DEPTH];

    logic w_wr_accept;
    logic w_pop;

    // Flags come only from the registered count, never from wr_en.
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    assign w_wr_accept = wr_en & ~full;
    assign w_pop       = (state_q == S_IDLE) & ~empty & ~tx_active;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (w_pop)   state_d = S_LAUNCH;
            S_LAUNCH:                 state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_done) state_d = S_GAP;
            S_GAP:                    state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = w_wr_accept ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop       ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        tx_data_d  = w_pop       ? mem_q[rd_ptr_q]       : tx_data_q;
        count_d    = count_q;
        case ({w_wr_accept, w_pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        // Clear wins over a same-cycle dropped write.
        if (ovf_clr)
            overflow_d = 1'b0;
        else if (wr_en && full)
            overflow_d = 1'b1;
        else
            overflow_d = overflow_q;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_valid_q <= w_pop;
            tx_data_q  <= tx_data_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_wr_accept)
            mem_q[wr_ptr_q] <= wr_data;
    end

    assign count         = count_q;
    assign overflow      = overflow_q;
    assign tx_data_valid = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire
